// File: rtl/ps2_key_tracker_pkg.sv
// Shared constants for the PS/2 key tracker: special scan codes, tracker
// state encodings and the frame check.
package ps2_key_tracker_pkg;

   localparam logic [7:0] PS2_BREAK = 8'hF0;
   localparam logic [7:0] PS2_EXT   = 8'hE0;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] HELD  = 2'd1;
   localparam logic [1:0] BREAK = 2'd2;

   // frame[0]=start, frame[8:1]=data LSB-first, frame[9]=odd parity, frame[10]=stop
   function automatic logic frame_ok(input logic [10:0] frame);
      return (frame[0] == 1'b0) && (frame[10] == 1'b1) && ((^frame[9:1]) == 1'b1);
   endfunction

endpackage

// File: rtl/ps2_key_tracker_rx.sv
// PS/2 receiver: synchronises the keyboard lines, assembles 11-bit frames
// and reports good bytes or rejected frames as single-cycle pulses.
module ps2_rx
   import ps2_key_tracker_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] code,
   output logic       code_valid,
   output logic       frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] data_sync_q;
   logic                   clk_prev_q;
   logic [3:0]             bit_cnt_q, bit_cnt_d;
   logic [9:0]             shift_q, shift_d;
   logic [TW-1:0]          to_cnt_q, to_cnt_d;
   logic [7:0]             code_q, code_d;
   logic                   valid_q, valid_d;
   logic                   err_q, err_d;
   logic                   fall_s;
   logic                   data_s;
   logic [10:0]            frame_s;

   assign fall_s  = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
   assign data_s  = data_sync_q[SYNC_STAGES-1];
   assign frame_s = {data_s, shift_q};

   // Bit capture, mid-frame timeout and frame check on the stop bit
   always_comb begin
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      to_cnt_d  = to_cnt_q;
      code_d    = code_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      if ((bit_cnt_q != 4'd0) && (to_cnt_q == TO_LIMIT)) begin
         bit_cnt_d = 4'd0;
         to_cnt_d  = '0;
      end else if (fall_s) begin
         to_cnt_d = '0;
         if (bit_cnt_q == 4'd10) begin
            bit_cnt_d = 4'd0;
            if (frame_ok(frame_s)) begin
               code_d  = frame_s[8:1];
               valid_d = 1'b1;
            end else begin
               err_d = 1'b1;
            end
         end else begin
            shift_d   = {data_s, shift_q[9:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
         end
      end else if (bit_cnt_q != 4'd0) begin
         to_cnt_d = to_cnt_q + 1'b1;
      end else begin
         to_cnt_d = '0;
      end
   end

   // Synchroniser chain, edge history and receiver state
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         clk_prev_q  <= 1'b1;
         bit_cnt_q   <= 4'd0;
         shift_q     <= 10'd0;
         to_cnt_q    <= '0;
         code_q      <= 8'd0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
         clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         to_cnt_q    <= to_cnt_d;
         code_q      <= code_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
      end
   end

   assign code       = code_q;
   assign code_valid = valid_q;
   assign frame_err  = err_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// Keyboard tracker: follows make/break sequences from ps2_rx and presents
// the held scan code and press count as nibbles for the bcd7seg digits.
module ps2_key_tracker
   import ps2_key_tracker_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       code_valid,
   output logic [7:0] code,
   output logic       frame_err,
   output logic [3:0] code_lo,
   output logic [3:0] code_hi,
   output logic       code_en,
   output logic [3:0] cnt_lo,
   output logic [3:0] cnt_hi
);

   logic [7:0] rx_code_s;
   logic       rx_valid_s;
   logic [1:0] state_q, state_d;
   logic [7:0] held_q, held_d;
   logic [7:0] cnt_q, cnt_d;
   logic       origin_q, origin_d;
   logic       code_en_q;

   ps2_rx #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
   ) u_rx (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .code       (rx_code_s),
      .code_valid (rx_valid_s),
      .frame_err  (frame_err)
   );

   // origin_q remembers whether BREAK was entered with a key held
   always_comb begin
      state_d  = state_q;
      held_d   = held_q;
      cnt_d    = cnt_q;
      origin_d = origin_q;
      if (rx_valid_s && (rx_code_s != PS2_EXT)) begin
         case (state_q)
            IDLE: begin
               if (rx_code_s == PS2_BREAK) begin
                  state_d  = BREAK;
                  origin_d = 1'b0;
               end else begin
                  held_d  = rx_code_s;
                  cnt_d   = cnt_q + 8'd1;
                  state_d = HELD;
               end
            end
            HELD: begin
               if (rx_code_s == PS2_BREAK) begin
                  state_d  = BREAK;
                  origin_d = 1'b1;
               end else if (rx_code_s != held_q) begin
                  held_d = rx_code_s;
                  cnt_d  = cnt_q + 8'd1;
               end else begin
                  state_d = HELD;
               end
            end
            BREAK: begin
               if (rx_code_s == held_q) begin
                  state_d = IDLE;
               end else if (origin_q) begin
                  state_d = HELD;
               end else begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Tracker state, held code, press count and display enable
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         held_q    <= 8'd0;
         cnt_q     <= 8'd0;
         origin_q  <= 1'b0;
         code_en_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         held_q    <= held_d;
         cnt_q     <= cnt_d;
         origin_q  <= origin_d;
         code_en_q <= (state_d != IDLE);
      end
   end

   assign code_valid = rx_valid_s;
   assign code       = rx_code_s;
   assign code_lo    = held_q[3:0];
   assign code_hi    = held_q[7:4];
   assign code_en    = code_en_q;
   assign cnt_lo     = cnt_q[3:0];
   assign cnt_hi     = cnt_q[7:4];

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: drives PS/2 frames bit by bit and
// checks pulses, held-code nibbles and the press count against hand values.
module tb_ps2_key_tracker;

   localparam int TIMEOUT = 200;
   localparam int SYNC    = 3;
   localparam int HALF    = 3;
   localparam int GAP     = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       code_valid;
   logic [7:0] code;
   logic       frame_err;
   logic [3:0] code_lo, code_hi, cnt_lo, cnt_hi;
   logic       code_en;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_valid = 0;
   int n_err = 0;
   int valid_cyc = 0;
   int stop_cyc = 0;
   logic [7:0] last_code = 8'h00;
   logic en_at_valid = 1'b0;
   logic en_after_valid = 1'b0;
   logic valid_d1 = 1'b0;

   ps2_key_tracker #(.TIMEOUT_CYCLES(TIMEOUT), .SYNC_STAGES(SYNC)) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .code_valid (code_valid),
      .code       (code),
      .frame_err  (frame_err),
      .code_lo    (code_lo),
      .code_hi    (code_hi),
      .code_en    (code_en),
      .cnt_lo     (cnt_lo),
      .cnt_hi     (cnt_hi)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Pulse monitor sampled away from the active edge
   always @(negedge clk) begin
      if (valid_d1) en_after_valid = code_en;
      valid_d1 = code_valid;
      if (code_valid) begin
         n_valid     = n_valid + 1;
         last_code   = code;
         valid_cyc   = cyc;
         en_at_valid = code_en;
      end
      if (frame_err) n_err = n_err + 1;
   end

   function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad);
      return {1'b1, (~(^b)) ^ bad, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = f[i];
         repeat (HALF) @(negedge clk);
         ps2_clk  = 1'b0;
         stop_cyc = cyc;
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      repeat (GAP) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad);
      send_bits(make_frame(b, bad), 11);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({code_valid, frame_err, code_en} !== 3'b000) begin
         errors++; $display("FAIL reset_flags: got %b expected 000", {code_valid, frame_err, code_en});
      end
      checks++;
      if (code !== 8'h00) begin
         errors++; $display("FAIL reset_code: got %h expected 00", code);
      end
      checks++;
      if ({code_hi, code_lo, cnt_hi, cnt_lo} !== 16'h0000) begin
         errors++; $display("FAIL reset_nibbles: got %h expected 0000", {code_hi, code_lo, cnt_hi, cnt_lo});
      end
   endtask

   task automatic test_press_release();
      int v0;
      do_reset();
      v0 = n_valid;
      send_frame(8'h1C, 1'b0);
      checks++;
      if (n_valid - v0 !== 1 || last_code !== 8'h1C) begin
         errors++; $display("FAIL press_valid: got %0d pulses code %h expected 1 pulse code 1c", n_valid - v0, last_code);
      end
      checks++;
      if (valid_cyc - stop_cyc !== SYNC + 1) begin
         errors++; $display("FAIL valid_latency: got %0d expected %0d", valid_cyc - stop_cyc, SYNC + 1);
      end
      checks++;
      if ({en_at_valid, en_after_valid} !== 2'b01) begin
         errors++; $display("FAIL en_latency: got %b expected 01", {en_at_valid, en_after_valid});
      end
      checks++;
      if ({code_en, code_hi, code_lo, cnt_hi, cnt_lo} !== 17'h1_1C01) begin
         errors++; $display("FAIL press_outputs: got %h expected 11c01", {code_en, code_hi, code_lo, cnt_hi, cnt_lo});
      end
      send_frame(8'hF0, 1'b0);
      send_frame(8'h1C, 1'b0);
      checks++;
      if (n_valid - v0 !== 3) begin
         errors++; $display("FAIL release_valid: got %0d expected 3", n_valid - v0);
      end
      checks++;
      if ({code_en, code_hi, code_lo, cnt_hi, cnt_lo} !== 17'h0_1C01) begin
         errors++; $display("FAIL release_outputs: got %h expected 01c01", {code_en, code_hi, code_lo, cnt_hi, cnt_lo});
      end
   endtask

   task automatic test_typematic();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         send_frame(8'h1C, 1'b0);
         checks++;
         if ({code_en, cnt_hi, cnt_lo} !== 9'h101) begin
            errors++; $display("FAIL typematic_%0d: got %h expected 101", i, {code_en, cnt_hi, cnt_lo});
         end
      end
      send_frame(8'hF0, 1'b0);
      checks++;
      if (code_en !== 1'b1) begin
         errors++; $display("FAIL typematic_break_en: got %b expected 1", code_en);
      end
      send_frame(8'h1C, 1'b0);
      checks++;
      if ({code_en, cnt_hi, cnt_lo} !== 9'h001) begin
         errors++; $display("FAIL typematic_release: got %h expected 001", {code_en, cnt_hi, cnt_lo});
      end
   endtask

   task automatic test_parity_err();
      int v0, e0;
      do_reset();
      v0 = n_valid;
      e0 = n_err;
      send_frame(8'h1C, 1'b1);
      checks++;
      if (n_err - e0 !== 1 || n_valid - v0 !== 0) begin
         errors++; $display("FAIL parity_pulses: got err %0d valid %0d expected err 1 valid 0", n_err - e0, n_valid - v0);
      end
      checks++;
      if ({code_en, cnt_hi, cnt_lo, code} !== 17'h0_0000) begin
         errors++; $display("FAIL parity_state: got %h expected 00000", {code_en, cnt_hi, cnt_lo, code});
      end
   endtask

   task automatic test_timeout();
      int v0, e0;
      do_reset();
      v0 = n_valid;
      e0 = n_err;
      send_bits(make_frame(8'h32, 1'b0), 5);
      repeat (TIMEOUT + 10) @(negedge clk);
      send_frame(8'h32, 1'b0);
      checks++;
      if (n_valid - v0 !== 1 || last_code !== 8'h32) begin
         errors++; $display("FAIL timeout_valid: got %0d pulses code %h expected 1 pulse code 32", n_valid - v0, last_code);
      end
      checks++;
      if (n_err - e0 !== 0) begin
         errors++; $display("FAIL timeout_err: got %0d expected 0", n_err - e0);
      end
      checks++;
      if ({code_en, cnt_hi, cnt_lo} !== 9'h101) begin
         errors++; $display("FAIL timeout_count: got %h expected 101", {code_en, cnt_hi, cnt_lo});
      end
   endtask

   task automatic test_rolling();
      do_reset();
      send_frame(8'h1C, 1'b0);
      send_frame(8'h32, 1'b0);
      send_frame(8'hE0, 1'b0);
      checks++;
      if ({code_en, code_hi, code_lo, cnt_hi, cnt_lo} !== 17'h1_3202) begin
         errors++; $display("FAIL rolling_press: got %h expected 13202", {code_en, code_hi, code_lo, cnt_hi, cnt_lo});
      end
      send_frame(8'hF0, 1'b0);
      send_frame(8'h1C, 1'b0);
      checks++;
      if ({code_en, code_hi, code_lo, cnt_hi, cnt_lo} !== 17'h1_3202) begin
         errors++; $display("FAIL rolling_other_break: got %h expected 13202", {code_en, code_hi, code_lo, cnt_hi, cnt_lo});
      end
      send_frame(8'hF0, 1'b0);
      send_frame(8'h32, 1'b0);
      checks++;
      if (code_en !== 1'b0) begin
         errors++; $display("FAIL rolling_release: got %b expected 0", code_en);
      end
      send_frame(8'hF0, 1'b0);
      checks++;
      if (code_en !== 1'b1) begin
         errors++; $display("FAIL idle_break_en: got %b expected 1", code_en);
      end
      send_frame(8'h55, 1'b0);
      checks++;
      if ({code_en, code_hi, code_lo, cnt_hi, cnt_lo} !== 17'h0_3202) begin
         errors++; $display("FAIL idle_break_other: got %h expected 03202", {code_en, code_hi, code_lo, cnt_hi, cnt_lo});
      end
   endtask

   task automatic test_wrap();
      int v0, e0;
      do_reset();
      v0 = n_valid;
      e0 = n_err;
      for (int i = 0; i < 256; i++) begin
         send_frame(8'h1C, 1'b0);
         send_frame(8'hF0, 1'b0);
         send_frame(8'h1C, 1'b0);
      end
      checks++;
      if (n_valid - v0 !== 768 || n_err - e0 !== 0) begin
         errors++; $display("FAIL wrap_pulses: got valid %0d err %0d expected 768 0", n_valid - v0, n_err - e0);
      end
      checks++;
      if ({code_en, cnt_hi, cnt_lo} !== 9'h000) begin
         errors++; $display("FAIL wrap_count: got %h expected 000", {code_en, cnt_hi, cnt_lo});
      end
      send_frame(8'h1C, 1'b0);
      checks++;
      if ({code_en, cnt_hi, cnt_lo} !== 9'h101) begin
         errors++; $display("FAIL wrap_next: got %h expected 101", {code_en, cnt_hi, cnt_lo});
      end
   endtask

   task automatic test_reset_midframe();
      do_reset();
      send_frame(8'h32, 1'b0);
      send_bits(make_frame(8'h1C, 1'b0), 4);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({code_valid, frame_err, code_en, code, code_hi, code_lo, cnt_hi, cnt_lo} !== 27'h0) begin
         errors++; $display("FAIL midreset_outputs: got %h expected 0",
                            {code_valid, frame_err, code_en, code, code_hi, code_lo, cnt_hi, cnt_lo});
      end
      send_frame(8'h15, 1'b0);
      checks++;
      if (last_code !== 8'h15 || code !== 8'h15) begin
         errors++; $display("FAIL midreset_code: got %h expected 15", last_code);
      end
      checks++;
      if ({code_en, code_hi, code_lo, cnt_hi, cnt_lo} !== 17'h1_1501) begin
         errors++; $display("FAIL midreset_state: got %h expected 11501", {code_en, code_hi, code_lo, cnt_hi, cnt_lo});
      end
   endtask

   initial begin
      test_reset();
      test_press_release();
      test_typematic();
      test_parity_err();
      test_timeout();
      test_rolling();
      test_wrap();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Upstream feeder for the bcd7seg digit decoders on the nvboard keyboard display.
- Receives the PS/2 keyboard serial stream and assembles 11-bit frames.
- Tracks make/break sequences and counts key presses.
- Presents the current scan code and the press count as 4-bit nibbles with enables, ready to drive bcd7seg.b and bcd7seg.en directly.

Parameters:
- TIMEOUT_CYCLES, 50000: clk cycles without a PS/2 falling edge mid-frame before the bit counter is resynchronised.
- SYNC_STAGES, 3: synchroniser depth on ps2_clk and ps2_data; minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock from the keyboard; asynchronous.
- ps2_data  in  1  raw PS/2 data; asynchronous.
- code_valid  out  1  one-cycle pulse; a good frame was received.
- code  out  8  last good frame byte (raw, including F0/E0).
- frame_err  out  1  one-cycle pulse; a frame was rejected.
- code_lo  out  4  held scan code [3:0].
- code_hi  out  4  held scan code [7:4].
- code_en  out  1  high while a key is held; drives bcd7seg.en for both code digits.
- cnt_lo  out  4  press count [3:0].
- cnt_hi  out  4  press count [7:4].

Behaviour:
- Reset:
  - All outputs 0.
  - FSM to IDLE; bit counter 0; press count 0; timeout counter 0; synchroniser stages loaded with 1 (PS/2 idle level).
  - Reset mid-frame discards the partial frame.
- Synchronisation and edge detect:
  - ps2_clk and ps2_data pass through SYNC_STAGES flops.
  - A falling edge is detected when the last two ps2_clk stages read 1 then 0.
  - ps2_data is sampled from its final synchroniser stage in the cycle the falling edge is detected.
- Frame format: start bit 0, then 8 data bits LSB-first, then odd parity, then stop bit 1.
- Frame capture:
  - Bit counter runs 0..10.
  - When bit 10 is sampled, the frame is checked: start==0, stop==1, and the XOR of data[7:0] and the parity bit equals 1.
  - The counter returns to 0 after bit 10 in all cases.
- Frame result, asserted the cycle after the stop-bit sample:
  - Pass: code <= data and code_valid pulses high for 1 cycle.
  - Fail: frame_err pulses high for 1 cycle; code, FSM and count are unchanged.
- Timeout:
  - While the bit counter is nonzero, the timeout counter increments every cycle and clears on each falling edge.
  - When it reaches TIMEOUT_CYCLES, the bit counter and timeout counter clear. There is no error pulse.
- Tracker FSM: states IDLE, HELD, BREAK. It acts only on code_valid.
  - E0 (extended prefix): ignored in every state.
  - IDLE, code F0: go to BREAK.
  - IDLE, any other code: held <= code; count +1; go to HELD.
  - HELD, code equal to held: typematic repeat; no change.
  - HELD, code F0: go to BREAK.
  - HELD, a different code: held <= code; count +1; stay in HELD (rolling press).
  - BREAK, code equal to held: go to IDLE.
  - BREAK, any other code: return to HELD if entered from HELD, else to IDLE. A 1-bit origin flag records this. The count is not changed.
- Held-code outputs:
  - code_en = 1 in HELD and BREAK, 0 in IDLE.
  - code_lo/code_hi show the held code and hold their last value while code_en is 0.
- Count: 8 bits, wraps 255 -> 0. It increments in the same cycle the FSM accepts the make code.
- Timing: all outputs are registered.
  - Latency from the stop-bit falling edge to code_valid: SYNC_STAGES+1 cycles.
  - code_en, count and the held-code nibbles update one cycle after code_valid.
- Back-to-back frames need no gap beyond the PS/2 protocol's own timing.

Decomposition:
- Shared package/header holds:
  - localparams PS2_BREAK = 8'hF0 and PS2_EXT = 8'hE0;
  - tracker state encodings IDLE=0, HELD=1, BREAK=2.
- Sub-module ps2_rx contains the synchroniser, edge detect, bit counter, timeout and frame check, and outputs code/code_valid/frame_err.
- ps2_key_tracker instantiates ps2_rx and contains the FSM and the counter.

Test Plan:
- Frames 1C, F0, 1C -> code_valid x3; after the first frame code_en=1, code_hi=1, code_lo=C, cnt=01; after the third frame code_en=0, cnt stays 01.
- Frame 1C sent five times, then F0, 1C -> cnt=01; code_en high throughout until the final 1C.
- Frame 1C with parity bit 1 -> frame_err pulse; no code_valid; cnt=00; code_en=0.
- 5 bits of a frame, idle for TIMEOUT_CYCLES+10, then full frame 32 -> code_valid with code=32; no frame_err.
- 256 sequences of (1C, F0, 1C) -> cnt=00 with code_en=0; one more press -> cnt=01.
- rst high for 1 cycle after 4 bits of frame 1C, then full frame 15 -> all outputs 0 after reset; next code_valid has code=15; cnt=01.
